chi_slice_stage: RTL and testbench

- Keccak chi step engine in the encoder round datapath. Sits directly upstream of the round-constant (iota) addition stage.
- Reads the 64 state slices (25 bits each) from a source slice memory and applies the chi nonlinearity row-wise to each slice.
- Writes each result to a destination slice memory, which the round-constant stage then consumes.
- Uses the same start/ready handshake as the other round stages.

---
 rtl/chi_slice_stage.sv | 103 ++++++++++
 tb/tb_chi_slice_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/chi_slice_stage.sv
// rtl/chi_slice_stage.sv - Keccak chi step over the 64 slices of a round state
// Streams slices from the source memory and writes chi(slice) one cycle later.
module chi_slice_stage #(
  parameter int N_SLICES = 64,
  parameter int ADDR_W   = 6,
  parameter int SLICE_W  = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [SLICE_W-1:0] rd_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [SLICE_W-1:0] wr_data,
  output logic               busy,
  output logic               ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SLICES - 1);

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  cnt;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;

  // Row-wise chi on a 5x5 plane, bit index 5*y + x.
  function automatic logic [SLICE_W-1:0] chi(input logic [SLICE_W-1:0] s);
    logic [SLICE_W-1:0] r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[5*y + x] = s[5*y + x] ^ (~s[5*y + (x + 1) % 5] & s[5*y + (x + 2) % 5]);
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state     <= state_nx;
      wr_en_q   <= rd_en;
      wr_addr_q <= rd_addr;
      if (state == S_WAIT)
        cnt <= '0;
      else if (state == S_RUN)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    rd_addr  = '0;
    busy     = 1'b0;
    ready    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (!start) state_nx = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = cnt;
        if (cnt == LAST) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        ready    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // rd_data is only meaningful the cycle after a read, so gate it with wr_en.
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_en_q ? chi(rd_data) : '0;

endmodule

// File: tb/tb_chi_slice_stage.sv
// tb/tb_chi_slice_stage.sv - scoreboard bench for chi_slice_stage
module tb_chi_slice_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [24:0] rd_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [24:0] wr_data;
  logic        busy;
  logic        ready;

  logic [24:0] mem [64];
  logic [30:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_on = 1'b0;

  chi_slice_stage dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  // Source memory: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= 25'($urandom);
  end

  function automatic logic [24:0] ref_chi(input logic [24:0] s);
    logic [24:0] r;
    int x, y;
    for (int i = 0; i < 25; i++) begin
      x = i % 5;
      y = i / 5;
      r[i] = s[i] ^ ((~s[y*5 + (x + 1) % 5]) & s[y*5 + (x + 2) % 5]);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected none", wr_addr, wr_data);
        end else begin
          logic [30:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[30:25]));
          check("wr_data", 32'(wr_data), 32'(e[24:0]));
        end
      end else begin
        check("idle_wr_bus", {1'b0, wr_addr, wr_data}, 32'h0);
      end
    end
  end

  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({6'(i), ref_chi(mem[i])});
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // mode 0: plain; 1: start pulses in Run and Done; 2: start held from Run through Done
  task automatic run_check(input int mode);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rd_en && lat < 20);
    check("r0_latency", lat, 1);
    if (!rd_en) return;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      check("rd_en_run", 32'(rd_en), 1);
      check("rd_addr", 32'(rd_addr), k);
      if (mode == 1 && k == 10) start = 1'b1;
      if (mode == 1 && k == 11) start = 1'b0;
      if (mode == 2 && k == 60) start = 1'b1;
    end
    @(negedge clk);
    check("drain_rd_en", 32'(rd_en), 0);
    check("drain_busy", 32'(busy), 1);
    check("drain_ready", 32'(ready), 0);
    @(negedge clk);
    check("done_ready", 32'(ready), 1);
    check("done_busy", 32'(busy), 1);
    if (mode == 1) start = 1'b1;
    @(negedge clk);
    check("after_ready", 32'(ready), 0);
    check("after_busy", 32'(busy), 0);
    check("writes_left", exp_q.size(), 0);
    if (mode == 1) start = 1'b0;
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      check("done_start_ignored", 32'(busy), 0);
    end
    if (mode == 2) begin
      @(negedge clk);
      check("rehold_wait_busy", 32'(busy), 1);
      check("rehold_no_read", 32'(rd_en), 0);
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_wr_bus", {1'b0, wr_addr, wr_data}, 32'h0);
    rst    = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    // all-zero source
    for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), 25'h0});
    start_pulse();
    run_check(0);

    // hand-computed slices
    mem[0] = 25'h0000001;
    mem[1] = 25'h0000002;
    mem[2] = 25'h0000020;
    mem[3] = 25'h1FFFFFF;
    exp_q.push_back({6'd0, 25'h0000009});
    exp_q.push_back({6'd1, 25'h0000012});
    exp_q.push_back({6'd2, 25'h0000120});
    exp_q.push_back({6'd3, 25'h1FFFFFF});
    for (int i = 4; i < 64; i++) exp_q.push_back({6'(i), 25'h0});
    start_pulse();
    run_check(0);

    // random state against the reference model
    foreach (mem[i]) mem[i] = 25'($urandom);
    push_run(64);
    start_pulse();
    run_check(0);

    // start held for 5 cycles
    push_run(64);
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_busy", 32'(busy), 1);
      check("hold_no_read", 32'(rd_en), 0);
    end
    start = 1'b0;
    run_check(0);

    // reset while rd_addr == 30
    push_run(30);
    start_pulse();
    begin
      int waited;
      waited = 0;
      while (!(rd_en && rd_addr == 6'd30) && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      check("reach_addr30", 32'(rd_en && rd_addr == 6'd30), 1);
    end
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rd_en", 32'(rd_en), 0);
    check("midrst_wr_en", 32'(wr_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(ready), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_writes_left", exp_q.size(), 0);
    push_run(64);
    start_pulse();
    run_check(0);

    // start pulses during Run and Done are ignored
    foreach (mem[i]) mem[i] = 25'($urandom);
    push_run(64);
    start_pulse();
    run_check(1);

    // start held through Done, then a second run after release
    push_run(64);
    start_pulse();
    run_check(2);
    push_run(64);
    @(negedge clk);
    check("rehold_still_no_read", 32'(rd_en), 0);
    start = 1'b0;
    run_check(0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
